// File: rtl/csr_pkg.sv
// Shared definitions for the counter CSR bank: privilege and CSR-op encodings,
// CSR addresses and counter slot indices.
package csr_pkg;

    typedef enum logic [1:0] {
        PRIV_USER    = 2'b00,
        PRIV_MACHINE = 2'b11
    } priv_mode_t;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_t;

    localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_TIME          = 12'hC01;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;

    // Counter slot k lives at address offset k: cycle, time, instret, hpm3...
    localparam logic [4:0] CNT_IDX_TIME = 5'd1;

    // Writable bits of mcounteren / mcountinhibit: 0, 2 and one per hpm counter.
    function automatic logic [31:0] cnt_ctrl_mask(input int unsigned num_hpm);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int unsigned i = 0; i < num_hpm; i++) m[3+i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/csr_counter_bank_if.sv
// CSR request/response channel between the pipeline (master) and the
// counter bank (slave).
interface csr_counter_bank_if;
    import csr_pkg::*;

    logic        req_valid;
    logic [11:0] req_addr;
    csr_op_t     req_op;
    logic [31:0] req_wdata;
    logic        req_src_zero;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_illegal;

    modport master (
        output req_valid, req_addr, req_op, req_wdata, req_src_zero,
        input  resp_valid, resp_rdata, resp_illegal
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_wdata, req_src_zero,
        output resp_valid, resp_rdata, resp_illegal
    );

endinterface

// File: rtl/csr_counter.sv
// One performance counter: per-cycle increment with inhibit, and 32-bit
// half writes that override that cycle's increment for the written half.
module csr_counter #(
    parameter int unsigned CNT_WIDTH = 64,
    parameter int unsigned INC_W     = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [31:0]          wdata_i,
    input  logic                 inhibit_i,
    input  logic [INC_W-1:0]     inc_i,
    output logic [CNT_WIDTH-1:0] value_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, sum;

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sum   = cnt_q + (inhibit_i ? '0 : CNT_WIDTH'(inc_i));
        cnt_d = sum;
        if (wr_lo_i) begin
            // Low half loaded; the carry out of the low half is dropped.
            cnt_d = {cnt_q[CNT_WIDTH-1:32], wdata_i};
        end else if (wr_hi_i) begin
            // High half loaded; low half keeps counting, its carry is dropped.
            cnt_d = CNT_WIDTH'({wdata_i, sum[31:0]});
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/csr_counter_bank.sv
// Counter CSR bank: cycle/time/instret/hpm counters with machine and user
// aliases, mcounteren/mcountinhibit, and a one-cycle registered response.
module csr_counter_bank
    import csr_pkg::*;
#(
    parameter int unsigned NUM_HPM   = 4,
    parameter int unsigned CNT_WIDTH = 64,
    parameter int unsigned RETIRE_W  = 2
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  priv_mode_t                             priv_mode,
    input  logic [RETIRE_W-1:0]                    instr_retired,
    input  logic                                   time_tick,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    csr_counter_bank_if.slave                      bus
);

    localparam int unsigned NUM_CNT   = 3 + NUM_HPM;
    localparam logic [31:0] CTRL_MASK = cnt_ctrl_mask(NUM_HPM);

    logic [CNT_WIDTH-1:0] cnt_val [NUM_CNT];
    logic [RETIRE_W-1:0]  cnt_inc [NUM_CNT];
    logic [NUM_CNT-1:0]   cnt_inh, cnt_wr_lo, cnt_wr_hi;
    logic [CNT_WIDTH-1:0] cnt_sel;

    logic [31:0] enable_q, enable_d, inhibit_q, inhibit_d;
    logic        resp_valid_q, resp_illegal_q, resp_illegal_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [4:0]  idx;
    logic        hi, cnt_ok, user, wants_write, illegal, do_write;
    logic        is_user_cnt, is_mach_cnt, is_enable, is_inhibit;
    logic [31:0] old_val, new_val;

    always_comb begin
        idx     = bus.req_addr[4:0];
        hi      = bus.req_addr[7];
        cnt_ok  = (32'(idx) < NUM_CNT);
        cnt_sel = '0;
        for (int unsigned k = 0; k < NUM_CNT; k++) begin
            if (idx == 5'(k)) cnt_sel = cnt_val[k];
        end

        is_user_cnt = (bus.req_addr[11:8] == CSR_CYCLE[11:8]) && (bus.req_addr[6:5] == 2'b00) && cnt_ok;
        is_mach_cnt = (bus.req_addr[11:8] == CSR_MCYCLE[11:8]) && (bus.req_addr[6:5] == 2'b00) && cnt_ok
                      && (idx != CNT_IDX_TIME);
        is_enable   = (bus.req_addr == CSR_MCOUNTEREN);
        is_inhibit  = (bus.req_addr == CSR_MCOUNTINHIBIT);
        user        = (priv_mode != PRIV_MACHINE);
        wants_write = (bus.req_op == CSR_OP_RW)
                      || (((bus.req_op == CSR_OP_RS) || (bus.req_op == CSR_OP_RC)) && !bus.req_src_zero);

        illegal = !(is_user_cnt || is_mach_cnt || is_enable || is_inhibit)
                  || (is_user_cnt && wants_write)
                  || (user && (is_mach_cnt || is_enable || is_inhibit))
                  || (user && is_user_cnt && !enable_q[idx]);
        do_write = bus.req_valid && !illegal && wants_write;

        if (is_enable)       old_val = enable_q;
        else if (is_inhibit) old_val = inhibit_q;
        else if (hi)         old_val = 32'(cnt_sel >> 32);
        else                 old_val = cnt_sel[31:0];

        new_val = old_val;
        case (bus.req_op)
            CSR_OP_RW: new_val = bus.req_wdata;
            CSR_OP_RS: new_val = old_val | bus.req_wdata;
            CSR_OP_RC: new_val = old_val & ~bus.req_wdata;
            default:   new_val = old_val;
        endcase

        enable_d  = (do_write && is_enable)  ? (new_val & CTRL_MASK) : enable_q;
        inhibit_d = (do_write && is_inhibit) ? (new_val & CTRL_MASK) : inhibit_q;

        for (int unsigned k = 0; k < NUM_CNT; k++) begin
            cnt_wr_lo[k] = do_write && is_mach_cnt && (idx == 5'(k)) && !hi;
            cnt_wr_hi[k] = do_write && is_mach_cnt && (idx == 5'(k)) && hi;
        end

        resp_rdata_d   = (bus.req_valid && !illegal) ? old_val : '0;
        resp_illegal_d = bus.req_valid && illegal;
    end

    // Time sits at inhibit bit 1, which the mask keeps at zero.
    always_comb begin
        cnt_inh    = inhibit_q[NUM_CNT-1:0];
        cnt_inc    = '{default: '0};
        cnt_inc[0] = RETIRE_W'(1);
        cnt_inc[1] = RETIRE_W'(time_tick);
        cnt_inc[2] = instr_retired;
        for (int unsigned i = 0; i < NUM_HPM; i++) cnt_inc[3+i] = RETIRE_W'(hpm_event[i]);
    end

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        csr_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_W     (RETIRE_W)
        ) u_cnt (
            .clock     (clock),
            .reset_n   (reset_n),
            .wr_lo_i   (cnt_wr_lo[k]),
            .wr_hi_i   (cnt_wr_hi[k]),
            .wdata_i   (new_val),
            .inhibit_i (cnt_inh[k]),
            .inc_i     (cnt_inc[k]),
            .value_o   (cnt_val[k])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enable_q       <= '0;
            inhibit_q      <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            enable_q       <= enable_d;
            inhibit_q      <= inhibit_d;
            resp_valid_q   <= bus.req_valid;
            resp_rdata_q   <= resp_rdata_d;
            resp_illegal_q <= resp_illegal_d;
        end
    end

    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_csr_counter_bank.sv
// Self-checking bench for csr_counter_bank: a vector table of CSR accesses plus
// hand-written multi-cycle sequences, all checked through a response scoreboard.
module tb_csr_counter_bank;
    import csr_pkg::*;

    localparam int unsigned NUM_HPM   = 4;
    localparam int unsigned CNT_WIDTH = 64;
    localparam int unsigned RETIRE_W  = 2;
    localparam int          NVEC      = 28;

    logic                clock   = 1'b0;
    logic                reset_n = 1'b1;
    priv_mode_t          priv_mode;
    logic [RETIRE_W-1:0] instr_retired;
    logic                time_tick;
    logic [NUM_HPM-1:0]  hpm_event;

    csr_counter_bank_if bus ();

    csr_counter_bank #(
        .NUM_HPM   (NUM_HPM),
        .CNT_WIDTH (CNT_WIDTH),
        .RETIRE_W  (RETIRE_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .priv_mode     (priv_mode),
        .instr_retired (instr_retired),
        .time_tick     (time_tick),
        .hpm_event     (hpm_event),
        .bus           (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] rdata;
        logic        illegal;
    } exp_t;

    typedef struct packed {
        priv_mode_t  priv;
        logic [11:0] addr;
        csr_op_t     op;
        logic [31:0] wdata;
        logic        src_zero;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    exp_t  sb_q[$];
    string name_q[$];
    exp_t  sb_e;
    string sb_n;
    int    total = 0;
    int    bad   = 0;
    logic  req_prev;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // A response is due exactly one cycle after each accepted request.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) req_prev <= 1'b0;
        else          req_prev <= bus.req_valid;
    end

    always @(negedge clock) begin
        if (reset_n) begin
            check("resp_valid_timing", 32'(bus.resp_valid), 32'(req_prev));
            if (bus.resp_valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got a response, want none pending");
                end else begin
                    sb_e = sb_q.pop_front();
                    sb_n = name_q.pop_front();
                    check({sb_n, ".rdata"}, bus.resp_rdata, sb_e.rdata);
                    check({sb_n, ".illegal"}, 32'(bus.resp_illegal), 32'(sb_e.illegal));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic req(input priv_mode_t p, input logic [11:0] a, input csr_op_t op,
                       input logic [31:0] wd, input logic sz,
                       input logic [31:0] er, input logic ei, input string nm);
        priv_mode        = p;
        bus.req_valid    = 1'b1;
        bus.req_addr     = a;
        bus.req_op       = op;
        bus.req_wdata    = wd;
        bus.req_src_zero = sz;
        sb_q.push_back('{rdata: er, illegal: ei});
        name_q.push_back(nm);
        step(1);
        bus.req_valid    = 1'b0;
        bus.req_op       = CSR_OP_NONE;
        bus.req_src_zero = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want normal end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [NVEC];
        // Runs with every counter frozen (inhibit all) so values are exact.
        vecs[0]  = '{PRIV_MACHINE, CSR_MCOUNTINHIBIT, CSR_OP_RW,   32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{PRIV_MACHINE, CSR_MCOUNTINHIBIT, CSR_OP_NONE, 32'h0,         1'b0, 32'h0000_007D, 1'b0};
        vecs[2]  = '{PRIV_MACHINE, CSR_MCYCLE,        CSR_OP_NONE, 32'h0,         1'b0, 32'd12,        1'b0};
        vecs[3]  = '{PRIV_MACHINE, CSR_MCYCLE,        CSR_OP_RW,   32'h1234_5678, 1'b0, 32'd12,        1'b0};
        vecs[4]  = '{PRIV_MACHINE, CSR_MCYCLE,        CSR_OP_RS,   32'h0000_000F, 1'b0, 32'h1234_5678, 1'b0};
        vecs[5]  = '{PRIV_MACHINE, CSR_MCYCLE,        CSR_OP_RC,   32'h0000_00F0, 1'b0, 32'h1234_567F, 1'b0};
        vecs[6]  = '{PRIV_MACHINE, CSR_CYCLE,         CSR_OP_NONE, 32'h0,         1'b0, 32'h1234_560F, 1'b0};
        vecs[7]  = '{PRIV_MACHINE, CSR_MCYCLEH,       CSR_OP_RW,   32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
        vecs[8]  = '{PRIV_MACHINE, CSR_CYCLEH,        CSR_OP_NONE, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[9]  = '{PRIV_MACHINE, CSR_MCOUNTEREN,    CSR_OP_RW,   32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0};
        vecs[10] = '{PRIV_MACHINE, CSR_MCOUNTEREN,    CSR_OP_NONE, 32'h0,         1'b0, 32'h0000_007D, 1'b0};
        vecs[11] = '{PRIV_MACHINE, 12'hB01,           CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[12] = '{PRIV_MACHINE, 12'hB07,           CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[13] = '{PRIV_MACHINE, 12'hC07,           CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[14] = '{PRIV_MACHINE, 12'h123,           CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[15] = '{PRIV_MACHINE, CSR_CYCLE,         CSR_OP_RW,   32'h0,         1'b0, 32'h0,         1'b1};
        vecs[16] = '{PRIV_MACHINE, CSR_MCYCLE,        CSR_OP_NONE, 32'h0,         1'b0, 32'h1234_560F, 1'b0};
        vecs[17] = '{PRIV_MACHINE, CSR_TIME,          CSR_OP_RS,   32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0};
        vecs[18] = '{PRIV_USER,    CSR_CYCLE,         CSR_OP_NONE, 32'h0,         1'b0, 32'h1234_560F, 1'b0};
        vecs[19] = '{PRIV_USER,    CSR_MCYCLE,        CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[20] = '{PRIV_USER,    CSR_MCOUNTEREN,    CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[21] = '{PRIV_MACHINE, CSR_MCOUNTEREN,    CSR_OP_RW,   32'h0,         1'b0, 32'h0000_007D, 1'b0};
        vecs[22] = '{PRIV_USER,    CSR_INSTRET,       CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[23] = '{PRIV_MACHINE, CSR_MCOUNTEREN,    CSR_OP_RW,   32'h0000_0004, 1'b0, 32'h0,         1'b0};
        vecs[24] = '{PRIV_USER,    CSR_INSTRET,       CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[25] = '{PRIV_USER,    CSR_CYCLE,         CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[26] = '{PRIV_MACHINE, CSR_MCOUNTINHIBIT, CSR_OP_RW,   32'h0000_0002, 1'b0, 32'h0000_007D, 1'b0};
        vecs[27] = '{PRIV_MACHINE, CSR_MCOUNTINHIBIT, CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b0};

        priv_mode        = PRIV_MACHINE;
        instr_retired    = '0;
        time_tick        = 1'b0;
        hpm_event        = '0;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_op       = CSR_OP_NONE;
        bus.req_wdata    = '0;
        bus.req_src_zero = 1'b0;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("reset.resp_valid",   32'(bus.resp_valid),   32'h0);
        check("reset.resp_rdata",   bus.resp_rdata,        32'h0);
        check("reset.resp_illegal", 32'(bus.resp_illegal), 32'h0);
        reset_n = 1'b1;

        // Ten free-running edges, then the read edge sees the pre-increment value.
        step(10);
        req(PRIV_MACHINE, CSR_MCYCLE, CSR_OP_NONE, 32'h0, 1'b0, 32'd10, 1'b0, "free_run_cycle");

        // Cycle reaches 12 at the edge that sets the inhibit; vecs[26..27] release it.
        for (int i = 0; i < NVEC; i++) begin
            req(vecs[i].priv, vecs[i].addr, vecs[i].op, vecs[i].wdata, vecs[i].src_zero,
                vecs[i].exp_rdata, vecs[i].exp_ill, $sformatf("vec%0d", i));
        end

        // Cycle is now 0xDEADBEEF_12345610. Loading all-ones low then writing the
        // high half in the next cycle drops the carry into the written half.
        req(PRIV_MACHINE, CSR_MCYCLE,  CSR_OP_RW,   32'hFFFF_FFFF, 1'b0, 32'h1234_5610, 1'b0, "roll_lo_wr");
        req(PRIV_MACHINE, CSR_MCYCLEH, CSR_OP_RW,   32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, "roll_hi_wr");
        req(PRIV_MACHINE, CSR_CYCLEH,  CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b0, "hi_wr_drops_carry");
        req(PRIV_MACHINE, CSR_CYCLE,   CSR_OP_NONE, 32'h0,         1'b0, 32'h1,         1'b0, "lo_after_hi_wr");
        // Low loaded with all-ones alone: two edges later cycle is 0x1_0000_0000.
        req(PRIV_MACHINE, CSR_MCYCLE,  CSR_OP_RW,   32'hFFFF_FFFF, 1'b0, 32'h2,         1'b0, "roll2_lo_wr");
        req(PRIV_MACHINE, CSR_CYCLEH,  CSR_OP_NONE, 32'h0,         1'b0, 32'h0,         1'b0, "roll2_hi_before");
        req(PRIV_MACHINE, CSR_CYCLEH,  CSR_OP_NONE, 32'h0,         1'b0, 32'h1,         1'b0, "roll2_hi_after");
        req(PRIV_MACHINE, CSR_CYCLE,   CSR_OP_NONE, 32'h0,         1'b0, 32'h1,         1'b0, "roll2_lo_after");

        // instret inhibit, then 5 cycles of 3 retirements.
        req(PRIV_MACHINE, CSR_MCOUNTINHIBIT, CSR_OP_RW, 32'h4, 1'b0, 32'h0, 1'b0, "inh_instret_set");
        instr_retired = 2'd3;
        step(5);
        instr_retired = 2'd0;
        req(PRIV_MACHINE, CSR_MINSTRET,      CSR_OP_NONE, 32'h0, 1'b0, 32'h0, 1'b0, "instret_inhibited");
        req(PRIV_MACHINE, CSR_MCOUNTINHIBIT, CSR_OP_RW,   32'h0, 1'b0, 32'h4, 1'b0, "inh_instret_clr");
        instr_retired = 2'd3;
        step(5);
        instr_retired = 2'd0;
        req(PRIV_MACHINE, CSR_MINSTRET, CSR_OP_NONE, 32'h0, 1'b0, 32'd15, 1'b0, "instret_plus15");
        req(PRIV_MACHINE, CSR_INSTRETH, CSR_OP_NONE, 32'h0, 1'b0, 32'h0,  1'b0, "instreth_zero");

        // hpm3 events; a suppressed RS does not block the increment, an RW does.
        hpm_event = 4'b0001;
        step(3);
        req(PRIV_MACHINE, CSR_MHPMCOUNTER3, CSR_OP_RS, 32'hFF, 1'b1, 32'd3, 1'b0, "hpm3_rs_src_zero");
        hpm_event = 4'b0000;
        req(PRIV_MACHINE, CSR_MHPMCOUNTER3, CSR_OP_NONE, 32'h0, 1'b0, 32'd4, 1'b0, "hpm3_still_counts");
        hpm_event = 4'b0001;
        req(PRIV_MACHINE, CSR_MHPMCOUNTER3, CSR_OP_RW, 32'd100, 1'b0, 32'd4, 1'b0, "hpm3_rw_with_event");
        hpm_event = 4'b0000;
        req(PRIV_MACHINE, CSR_MHPMCOUNTER3, CSR_OP_NONE, 32'h0, 1'b0, 32'd100, 1'b0, "hpm3_write_wins");
        req(PRIV_USER,    CSR_HPMCOUNTER3,  CSR_OP_NONE, 32'h0, 1'b0, 32'h0,   1'b1, "hpm3_user_disabled");
        hpm_event = 4'b0010;
        step(2);
        hpm_event = 4'b0000;
        req(PRIV_MACHINE, 12'hB04, CSR_OP_NONE, 32'h0, 1'b0, 32'd2, 1'b0, "hpm4_event_bit1");

        // time keeps counting with every inhibit bit set.
        req(PRIV_MACHINE, CSR_MCOUNTINHIBIT, CSR_OP_RW, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, "inh_all");
        time_tick = 1'b1;
        step(4);
        time_tick = 1'b0;
        req(PRIV_MACHINE, CSR_TIME, CSR_OP_NONE, 32'h0, 1'b0, 32'd4, 1'b0, "time_not_inhibited");

        // Reset asserted while a request is in flight: no response may appear.
        bus.req_valid = 1'b1;
        bus.req_addr  = CSR_MCYCLE;
        bus.req_op    = CSR_OP_NONE;
        #2 reset_n = 1'b0;
        #1 bus.req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("midreset.resp_valid",   32'(bus.resp_valid),   32'h0);
        check("midreset.resp_rdata",   bus.resp_rdata,        32'h0);
        check("midreset.resp_illegal", 32'(bus.resp_illegal), 32'h0);
        reset_n = 1'b1;
        req(PRIV_MACHINE, CSR_MCOUNTINHIBIT, CSR_OP_NONE, 32'h0, 1'b0, 32'h0, 1'b0, "post_reset_inhibit");
        req(PRIV_MACHINE, CSR_TIME,          CSR_OP_NONE, 32'h0, 1'b0, 32'h0, 1'b0, "post_reset_time");
        req(PRIV_MACHINE, CSR_MCYCLE,        CSR_OP_NONE, 32'h0, 1'b0, 32'd2, 1'b0, "post_reset_cycle");

        step(2);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
